// File: rtl/seg7_pkg.sv
// Types and defaults shared by the seg7 display path: arbiter FSM states,
// default timing constants and the BCD digit type also used by seg7.
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } arb_state_e;

  localparam logic [7:0] DWELL_TICKS_DEFAULT  = 8'd10;
  localparam logic [7:0] BLANK_CYCLES_DEFAULT = 8'd4;

  typedef logic [3:0] bcd_t;

  // A zero dwell request falls back to the build-time default.
  function automatic logic [7:0] effective_dwell(input logic [7:0] cfg,
                                                 input logic [7:0] dflt);
    return (cfg == 8'd0) ? dflt : cfg;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request searching upward
// from last_grant+1, wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic                       gnt_valid,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx
);

  localparam int IDW = $clog2(NUM_REQ);

  logic [IDW-1:0] cand;

  // Walk from the farthest offset down so the nearest hit is the last write.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDW'((int'(last_grant) + k) % NUM_REQ);
      if (req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/seg7_display_arbiter.sv
// Time-shares the seg7 BCD digit path among NUM_REQ requesters: round-robin
// grant, dwell of D prescaled ticks, then a fixed blank gap before re-arbitration.
module seg7_display_arbiter
  import seg7_pkg::*;
#(
  parameter int         NUM_REQ      = 4,
  parameter logic [23:0] PRESCALE    = 24'd1_000_000,
  parameter logic [7:0] DWELL_TICKS  = DWELL_TICKS_DEFAULT,
  parameter logic [7:0] BLANK_CYCLES = BLANK_CYCLES_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [4*NUM_REQ-1:0]       value,
  input  logic [7:0]                 cfg_dwell,
  output logic [NUM_REQ-1:0]         ack,
  output logic [3:0]                 digit,
  output logic                       digit_valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic [1:0]                 dbg_state
);

  localparam int IDW = $clog2(NUM_REQ);

  arb_state_e         state_q;
  logic [NUM_REQ-1:0] ack_q;
  bcd_t               digit_q;
  logic               valid_q;
  logic               busy_q;
  logic [IDW-1:0]     grant_q;
  logic [IDW-1:0]     last_q;
  logic [23:0]        presc_q;
  logic [7:0]         dwell_cnt_q;
  logic [7:0]         dwell_q;
  logic [7:0]         blank_cnt_q;

  logic               gnt_valid;
  logic [IDW-1:0]     gnt_idx;
  logic               tick_d;
  logic               dwell_done_d;
  logic [7:0]         eff_dwell_d;
  bcd_t               pick_digit_d;
  logic [NUM_REQ-1:0] ack_onehot_d;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req        (req),
    .last_grant (last_q),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx)
  );

  assign tick_d       = (presc_q == (PRESCALE - 24'd1));
  assign dwell_done_d = ((dwell_cnt_q + 8'd1) == dwell_q);
  assign eff_dwell_d  = effective_dwell(cfg_dwell, DWELL_TICKS);
  assign pick_digit_d = value[{gnt_idx, 2'b00} +: 4];
  assign ack_onehot_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ack_q       <= '0;
      digit_q     <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      grant_q     <= '0;
      last_q      <= IDW'(NUM_REQ - 1);
      presc_q     <= '0;
      dwell_cnt_q <= '0;
      dwell_q     <= '0;
      blank_cnt_q <= '0;
    end else begin
      ack_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (gnt_valid) begin
            state_q     <= ST_SHOW;
            digit_q     <= pick_digit_d;
            grant_q     <= gnt_idx;
            last_q      <= gnt_idx;
            dwell_q     <= eff_dwell_d;
            presc_q     <= '0;
            dwell_cnt_q <= '0;
            valid_q     <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        ST_SHOW: begin
          // A dropped request wins over completion: no ack for an abandoned grant.
          if (!req[grant_q]) begin
            state_q     <= ST_BLANK;
            valid_q     <= 1'b0;
            blank_cnt_q <= '0;
          end else if (tick_d && dwell_done_d) begin
            state_q     <= ST_BLANK;
            valid_q     <= 1'b0;
            blank_cnt_q <= '0;
            ack_q       <= ack_onehot_d;
          end else if (tick_d) begin
            presc_q     <= '0;
            dwell_cnt_q <= dwell_cnt_q + 8'd1;
          end else begin
            presc_q     <= presc_q + 24'd1;
          end
        end
        ST_BLANK: begin
          if (blank_cnt_q == (BLANK_CYCLES - 8'd1)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            blank_cnt_q <= blank_cnt_q + 8'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ack         = ack_q;
  assign digit       = digit_q;
  assign digit_valid = valid_q;
  assign grant_id    = grant_q;
  assign busy        = busy_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_seg7_display_arbiter.sv
// Bench for seg7_display_arbiter: table of single-grant transactions, directed
// multi-cycle corner sequences, and random traffic against a countdown model.
`timescale 1ns/1ps
module tb_seg7_display_arbiter;

  localparam int N         = 4;
  localparam int P         = 4;
  localparam int BLANK     = 2;
  localparam int DEF_DWELL = 10;
  localparam int W         = 6;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [4*N-1:0] value = '0;
  logic [7:0]     cfg_dwell = '0;
  logic [N-1:0]   ack;
  logic [3:0]     digit;
  logic           digit_valid;
  logic [1:0]     grant_id;
  logic           busy;
  logic [1:0]     dbg_state;

  seg7_display_arbiter #(
    .NUM_REQ      (N),
    .PRESCALE     (24'd4),
    .DWELL_TICKS  (8'd10),
    .BLANK_CYCLES (8'd2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .value       (value),
    .cfg_dwell   (cfg_dwell),
    .ack         (ack),
    .digit       (digit),
    .digit_valid (digit_valid),
    .grant_id    (grant_id),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Display time is a single countdown of D*P cycles, blank a countdown of BLANK.
  int           m_show_left = 0;
  int           m_blank_left = 0;
  int           m_last = N - 1;
  int           m_gid = 0;
  logic [3:0]   m_digit = '0;
  logic [N-1:0] m_ack = '0;
  bit           m_found;
  int           m_idx;
  int           m_d;

  always @(posedge clk) begin
    if (reset) begin
      m_show_left  = 0;
      m_blank_left = 0;
      m_last       = N - 1;
      m_gid        = 0;
      m_digit      = '0;
      m_ack        = '0;
    end else begin
      m_ack = '0;
      if (m_show_left > 0) begin
        if (!req[m_gid]) begin
          m_show_left  = 0;
          m_blank_left = BLANK;
        end else if (m_show_left == 1) begin
          m_show_left  = 0;
          m_blank_left = BLANK;
          m_ack        = N'(1) << m_gid;
        end else begin
          m_show_left--;
        end
      end else if (m_blank_left > 0) begin
        m_blank_left--;
      end else if (req != '0) begin
        m_found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          m_idx = (m_last + k) % N;
          if (!m_found && req[m_idx]) begin
            m_found = 1'b1;
            m_gid   = m_idx;
          end
        end
        m_last      = m_gid;
        m_digit     = value[4*m_gid +: 4];
        m_d         = (cfg_dwell == 8'd0) ? DEF_DWELL : int'(cfg_dwell);
        m_show_left = m_d * P;
        exp_q.push_back({2'(m_gid), m_digit});
      end
    end
  end

  // ---------------- scoreboard / per-cycle checker ----------------
  logic prev_valid = 1'b0;
  logic [W-1:0] sb_exp;

  always @(negedge clk) begin
    if (chk_en) begin
      check("model/digit_valid", digit_valid, (m_show_left > 0));
      check("model/busy", busy, (m_show_left > 0) || (m_blank_left > 0));
      check("model/ack", ack, m_ack);
      check("model/digit", digit, m_digit);
      check("model/grant_id", grant_id, m_gid);
      if (digit_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          check("sb/unexpected_grant", {grant_id, digit}, 32'hFFFF_FFFF);
        end else begin
          sb_exp = exp_q.pop_front();
          check("sb/grant", {grant_id, digit}, sb_exp);
        end
      end
    end
    prev_valid = digit_valid;
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    cyc(2);
    reset = 1'b0;
  endtask

  task automatic run_grant(input string tag, input int exp_id, input int exp_digit,
                           input int exp_len, input bit late_change);
    int len;
    cyc(1);
    check({tag, "/valid_latency"}, digit_valid, 1);
    check({tag, "/busy"}, busy, 1);
    check({tag, "/grant_id"}, grant_id, exp_id);
    check({tag, "/digit"}, digit, exp_digit);
    if (late_change) begin
      value     = 16'h9999;
      cfg_dwell = 8'd7;
    end
    len = 0;
    while (digit_valid === 1'b1 && len < 2000) begin
      len++;
      cyc(1);
    end
    check({tag, "/show_len"}, len, exp_len);
    check({tag, "/digit_held"}, digit, exp_digit);
    check({tag, "/ack"}, ack, 32'(1) << exp_id);
    req[exp_id] = 1'b0;
    cyc(1);
    check({tag, "/ack_one_cycle"}, ack, 0);
    check({tag, "/blank2_busy"}, busy, 1);
    check({tag, "/blank2_valid"}, digit_valid, 0);
    cyc(1);
    check({tag, "/idle_busy"}, busy, 0);
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic [15:0]  value;
    logic [7:0]   cfg;
    int           exp_id;
    int           exp_digit;
    int           exp_len;
  } vec_t;

  vec_t tbl[6];

  task automatic seq_round_robin();
    int order[$];
    int ra[N];
    int exp_order[4];
    int c;
    logic was_valid;
    exp_order = '{0, 1, 3, 0};
    for (int i = 0; i < N; i++) ra[i] = -1;
    do_reset();
    value = 16'h4321; cfg_dwell = 8'd1; req = 4'b1011;
    c = 0; was_valid = 1'b0;
    while (order.size() < 4 && c < 300) begin
      cyc(1);
      c++;
      if (digit_valid && !was_valid) order.push_back(int'(grant_id));
      if (ack != '0) begin
        check("rr/ack_matches_grant", ack, 32'(1) << grant_id);
        for (int i = 0; i < N; i++) if (ack[i]) begin req[i] = 1'b0; ra[i] = c + 3; end
      end
      for (int i = 0; i < N; i++) if (ra[i] == c) begin req[i] = 1'b1; ra[i] = -1; end
      was_valid = digit_valid;
    end
    check("rr/grant_count", order.size(), 4);
    for (int i = 0; i < 4; i++) if (i < order.size()) check("rr/order", order[i], exp_order[i]);
  endtask

  task automatic seq_abort();
    do_reset();
    value = 16'h0600; cfg_dwell = 8'd3; req = 4'b0100;
    cyc(1);
    check("abort/grant_id", grant_id, 2);
    cyc(4);
    check("abort/valid_show5", digit_valid, 1);
    req = 4'b0000;
    cyc(1);
    check("abort/blank_valid", digit_valid, 0);
    check("abort/no_ack", ack, 0);
    check("abort/blank_busy", busy, 1);
    req = 4'b1001; value = 16'h7000;
    cyc(1);
    check("abort/no_ack2", ack, 0);
    cyc(1);
    check("abort/idle_busy", busy, 0);
    cyc(1);
    check("abort/next_valid", digit_valid, 1);
    check("abort/next_id", grant_id, 3);
    check("abort/next_digit", digit, 7);
  endtask

  task automatic seq_drop_on_complete();
    do_reset();
    value = 16'h0003; cfg_dwell = 8'd1; req = 4'b0001;
    cyc(1);
    cyc(3);
    check("dropend/last_show", digit_valid, 1);
    req = 4'b0000;
    cyc(1);
    check("dropend/valid", digit_valid, 0);
    check("dropend/no_ack", ack, 0);
  endtask

  task automatic seq_reset_mid_show();
    do_reset();
    value = 16'h0005; cfg_dwell = 8'd2; req = 4'b0001;
    cyc(4);
    check("rst_mid/in_show", digit_valid, 1);
    reset = 1'b1;
    cyc(1);
    check("rst_mid/ack", ack, 0);
    check("rst_mid/digit", digit, 0);
    check("rst_mid/valid", digit_valid, 0);
    check("rst_mid/busy", busy, 0);
    check("rst_mid/grant_id", grant_id, 0);
    reset = 1'b0; req = 4'b1111; value = 16'h4321; cfg_dwell = 8'd1;
    cyc(1);
    check("rst_mid/first_id", grant_id, 0);
    check("rst_mid/first_digit", digit, 1);
  endtask

  task automatic seq_random(input int ncyc);
    do_reset();
    for (int c = 0; c < ncyc; c++) begin
      for (int i = 0; i < N; i++) begin
        if (ack[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 5) == 0) req[i] = 1'b1;
      end
      if (digit_valid && $urandom_range(0, 149) == 0) req[grant_id] = 1'b0;
      value     = 16'($urandom);
      cfg_dwell = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 4));
      cyc(1);
    end
  endtask

  // ---------------- main ----------------
  initial begin
    tbl[0] = '{req: 4'b0001, value: 16'h0007, cfg: 8'd3,   exp_id: 0, exp_digit: 7, exp_len: 12};
    tbl[1] = '{req: 4'b0100, value: 16'h0900, cfg: 8'd1,   exp_id: 2, exp_digit: 9, exp_len: 4};
    tbl[2] = '{req: 4'b1100, value: 16'h5300, cfg: 8'd2,   exp_id: 2, exp_digit: 3, exp_len: 8};
    tbl[3] = '{req: 4'b1000, value: 16'h8000, cfg: 8'd0,   exp_id: 3, exp_digit: 8, exp_len: 40};
    tbl[4] = '{req: 4'b1111, value: 16'h4321, cfg: 8'd5,   exp_id: 0, exp_digit: 1, exp_len: 20};
    tbl[5] = '{req: 4'b0110, value: 16'h0650, cfg: 8'd255, exp_id: 1, exp_digit: 5, exp_len: 1020};

    do_reset();
    chk_en = 1'b1;
    check("reset/ack", ack, 0);
    check("reset/digit", digit, 0);
    check("reset/valid", digit_valid, 0);
    check("reset/busy", busy, 0);
    check("reset/grant_id", grant_id, 0);

    for (int i = 0; i < 6; i++) begin
      do_reset();
      value = tbl[i].value; cfg_dwell = tbl[i].cfg; req = tbl[i].req;
      run_grant($sformatf("vec%0d", i), tbl[i].exp_id, tbl[i].exp_digit, tbl[i].exp_len, 1'b0);
    end

    do_reset();
    value = 16'h0050; cfg_dwell = 8'd2; req = 4'b0010;
    run_grant("late_change", 1, 5, 8, 1'b1);

    seq_round_robin();
    seq_abort();
    seq_drop_on_complete();
    seq_reset_mid_show();
    seq_random(3000);

    do_reset();
    cyc(2);
    check("sb/queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_display_arbiter.md
# seg7_display_arbiter

Time-shares the single BCD digit path feeding `seg7` among up to `NUM_REQ` requesters. Requests are served round-robin. Each winner's digit is held on the display for a programmable dwell, measured in prescaled ticks, then the display is blanked briefly before the next grant. The block sits between the counter/status sources and the `seg7` decoder. `digit` drives `seg7.counter` directly. `digit_valid` gates the decoded segments in the top level.

## Interface
Parameters:
- `NUM_REQ`, default 4, number of requesters (2..8).
- `PRESCALE`, default 24'd1_000_000, clk cycles per tick (≥1).
- `DWELL_TICKS`, default 8'd10, dwell used when `cfg_dwell == 0`.
- `BLANK_CYCLES`, default 8'd4, blank gap in clk cycles (1..255).

Ports:
- `clk`, in, 1, single clock; all logic is on its rising edge.
- `reset`, in, 1, synchronous, active-high.
- `req`, in, NUM_REQ, per-requester level request.
- `value`, in, 4*NUM_REQ, BCD digit of requester i on bits [4i+3:4i].
- `cfg_dwell`, in, 8, dwell in ticks; 0 selects `DWELL_TICKS`.
- `ack`, out, NUM_REQ, one-hot 1-cycle pulse when a dwell completes.
- `digit`, out, 4, digit to `seg7`.
- `digit_valid`, out, 1, 1 = show `digit`, 0 = blank.
- `grant_id`, out, $clog2(NUM_REQ), index of the current/last grantee.
- `busy`, out, 1, high in every state except IDLE.

## Operation
- FSM states are IDLE, SHOW and BLANK.
- **IDLE → SHOW:** taken when any `req` bit is high. The round-robin arbiter picks the first asserted requester, searching upward from `last_grant+1` and wrapping.
  - On entry to SHOW: capture `value` slice into `digit`, `grant_id`, and the effective dwell. Clear the prescaler and dwell counters. Set `last_grant`.
- **SHOW:**
  - The prescaler counts 0..PRESCALE-1. A tick is generated when the prescaler equals PRESCALE-1.
  - The dwell counter increments on each tick. When the dwell count reaches the effective dwell, the block pulses `ack[grant_id]` and goes to BLANK.
  - If `req[grant_id]` is low in any SHOW cycle, the block aborts to BLANK with no ack, including on the completing cycle.
- **BLANK:**
  - `digit_valid` = 0.
  - Lasts exactly `BLANK_CYCLES` cycles, then returns to IDLE.
- Changes to `value` and `cfg_dwell` during SHOW are ignored; both are sampled at grant only.
- Requests from non-granted channels never affect the current grant. They wait for the next IDLE arbitration.
- Requesters hold `req` until they see `ack`. Requesters drop `req` in the cycle after `ack`, or they are re-eligible at their next round-robin turn.
- Width rules:
  - The prescaler is 24-bit.
  - The dwell counter is 8-bit; the effective dwell is always 1..255, so no wrap occurs.
  - The `last_grant` pointer wraps modulo NUM_REQ.

## Timing
- Reset values:
  - state = IDLE
  - `ack` = 0, `digit` = 0, `digit_valid` = 0, `busy` = 0
  - `grant_id` = 0
  - `last_grant` = NUM_REQ-1, so requester 0 has highest priority after reset.
  - All counters = 0.
- **Grant latency:** `req` high in IDLE at cycle t gives the following at cycle t+1:
  - `digit_valid` = 1
  - `digit` and `grant_id` updated
  - `busy` = 1
- **Dwell:** `digit_valid` stays high for exactly `D*PRESCALE` cycles, where D is the effective dwell.
- **Ack timing:** `ack` is registered. It is high in the first BLANK cycle, for exactly one cycle.
- **Turnaround:** the minimum gap between consecutive grants is `BLANK_CYCLES` + 1 cycles (the BLANK cycles plus one IDLE cycle).
- **Reset mid-SHOW or mid-BLANK:** no ack is produced. All outputs take their reset values in the next cycle.

## Structure
- **Shared package `seg7_pkg`:**
  - State enum (IDLE/SHOW/BLANK).
  - Default constants `DWELL_TICKS_DEFAULT` and `BLANK_CYCLES_DEFAULT`.
  - The 4-bit BCD digit type, shared with `seg7`.
- **Sub-module `rr_arbiter`:** purely combinational, parameterised on NUM_REQ.
  - Inputs: `req` and `last_grant`.
  - Outputs: `gnt_valid` and `gnt_idx`.
- The controller holds the FSM, counters and capture registers.

## Test plan
Bench parameters: `PRESCALE`=4, `BLANK_CYCLES`=2, `NUM_REQ`=4.
- **Single request:** reset, then `req`=4'b0001, `value[3:0]`=7, `cfg_dwell`=3 → `digit`=7 and `digit_valid`=1 for exactly 12 cycles; `ack`=4'b0001 for 1 cycle; 2 blank cycles; `busy` low after.
- **Round-robin:** `req`=4'b1011 held; each requester drops its bit 1 cycle after its ack and reasserts after → grant order 0,1,3,0; each `ack` matches `grant_id`.
- **Abort:** grant ch2, then drop `req[2]` in the 5th SHOW cycle → BLANK starts next cycle; no `ack`; next grant follows normally.
- **Default dwell:** `cfg_dwell`=0 with `DWELL_TICKS`=10 → display held 40 cycles.
- **Late changes and boundaries:** change `value` and `cfg_dwell` mid-SHOW → `digit` and dwell unchanged. Also drop `req` exactly on the completing cycle → no `ack`.
- **Reset mid-SHOW:** assert `reset` for 1 cycle mid-SHOW → all outputs 0, no `ack`. With `req`=4'b1111 afterwards → first grant goes to ch0.
